coin_input: RTL and testbench
=============================

COIN_INPUT -- requirements
Module: coin_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive cycles a synchronised key level must differ from the debounced level before it is accepted (10 ms at 50 MHz); legal range 1 to 2^20.
REQ-002 Parameter KEY_ACTIVE_LOW, default 1, selects the pressed level of all raw key inputs: 1 means pressed = 0, 0 means pressed = 1.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset is asynchronous and active-low.
REQ-005 key1_in  input  1  raw, asynchronous, bouncing 1-yuan button.
REQ-006 key5_in  input  1  raw, asynchronous, bouncing 5-yuan button.
REQ-007 key10_in  input  1  raw, asynchronous, bouncing 10-yuan button.
REQ-008 rmb1  output  1  registered single-cycle 1-yuan coin strobe to the money accumulator.
REQ-009 rmb5  output  1  registered single-cycle 5-yuan coin strobe.
REQ-010 rmb10  output  1  registered single-cycle 10-yuan coin strobe.
REQ-011 busy  output  1  high while any accepted press is still pending emission.

Function
REQ-012 Each key input passes through a two-flop synchroniser; after reset both flops hold the inactive level.
REQ-013 Each channel has a debounced level and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-014 Counter behaviour: clears whenever the synchronised level equals the debounced level; increments by one while they differ.
REQ-015 Acceptance: when the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synchronised value and the counter clears.
REQ-016 A press event occurs only on a debounced inactive-to-active transition; releases generate no event.
REQ-017 A press event sets that channel's pending bit; the bit clears in the cycle its strobe is issued.
REQ-018 Arbitration: each cycle at most one strobe is issued, for the highest-priority channel among pending bits and same-cycle press events; priority is 1 > 5 > 10.
REQ-019 rmb1, rmb5 and rmb10 are mutually exclusive, never high for more than one consecutive cycle on the same channel per press, and are high for exactly one cycle per accepted press.
REQ-020 Latency with no contention: the strobe is high for the cycle following the (DEBOUNCE_CYCLES+3)th rising edge after the raw key settles active.
REQ-021 Pulses shorter than DEBOUNCE_CYCLES synchronised cycles, and bounce that returns to the debounced level before acceptance, produce no event.
REQ-022 Overrun: a press event on a channel whose pending bit is still set is discarded, leaving the pending bit set so that only one strobe is issued.
REQ-023 busy equals the OR of the pending bits, registered alongside the strobes.

Reset
REQ-024 While reset_n is low: all outputs are 0, synchronisers and debounced levels are inactive, counters are 0, and pending bits are clear; this holds immediately, with no clock required.
REQ-025 A reset asserted mid-debounce or with presses pending discards them; no strobe from before reset appears after it.
REQ-026 A key held active through reset release is treated as a new press and yields one strobe after the REQ-020 latency.

Structure
REQ-027 Shared package coin_pkg holds: the coin_t enum (COIN1, COIN5, COIN10), priority order, and the DEBOUNCE_CYCLES default constant.
REQ-028 The synchroniser, debounce and press-event logic form sub-module coin_debounce, instantiated three times; arbitration and pending logic stay in coin_input.

Verification (benches override DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1)
REQ-029 key5_in driven low for 20 cycles, then high -> rmb5 is high exactly one cycle, after rising edge 7; rmb1 and rmb10 stay 0; no pulse on release.
REQ-030 key1_in toggled every 2 cycles for 12 cycles, then held low -> exactly one rmb1 pulse, issued 7 edges after the final settle.
REQ-031 key1_in, key5_in and key10_in all driven low in the same cycle and held -> rmb1, rmb5 and rmb10 on three consecutive cycles in that order; busy high from the rmb1 cycle through the rmb5 cycle; never two strobes at once.
REQ-032 key10_in low for 3 cycles only -> no rmb10 and busy stays 0.
REQ-033 reset_n pulsed low 5 cycles into a key5 debounce, key still held -> all outputs 0 during reset; exactly one rmb5 issued 7 edges after reset_n rises.
REQ-034 Random bounce on all keys over 10,000 cycles, checked against a reference counter -> strobe count per channel equals accepted presses, and outputs are always one-hot or zero.

Source files
------------

// File: rtl/coin_pkg.sv
// ----------------------------------------------------------------------------
// coin_pkg
// Shared definitions for the coin input block: the coin identifiers, the
// arbitration priority order, the default debounce length and the priority
// pick helper used by the arbiter.
// ----------------------------------------------------------------------------
package coin_pkg;

    // Coin identifiers; the value doubles as the bit index of each channel
    // inside the per-channel vectors used by coin_input.
    typedef enum logic [1:0] {
        COIN1  = 2'd0,
        COIN5  = 2'd1,
        COIN10 = 2'd2
    } coin_t;

    localparam int NUM_COINS = 3;

    // 10 ms at 50 MHz.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    // Arbitration order, highest priority first.
    localparam coin_t PRIO_ORDER [NUM_COINS] = '{COIN1, COIN5, COIN10};

    // Returns a one-hot (or zero) grant for the highest-priority requester.
    function automatic logic [NUM_COINS-1:0] pick_coin(input logic [NUM_COINS-1:0] req);
        logic [NUM_COINS-1:0] grant;
        grant = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (req[PRIO_ORDER[i]] && (grant == '0)) begin
                grant[PRIO_ORDER[i]] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// ----------------------------------------------------------------------------
// coin_debounce
// One coin button channel: two-flop synchroniser, counter-based debouncer and
// press-event detector.
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   key      in   raw, asynchronous, bouncing button level
//   press    out  registered one-cycle pulse on each accepted
//                 inactive-to-active debounced transition
//
// A new synchronised level must persist for DEBOUNCE_CYCLES consecutive
// cycles before it replaces the debounced level. Releases are debounced the
// same way but never produce a press pulse.
// ----------------------------------------------------------------------------
module coin_debounce
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key,
    output logic press
);

    localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic            IDLE_LEVEL = KEY_ACTIVE_LOW;

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             accept;

    assign differ = (sync2 != level);
    // The counter has already seen DEBOUNCE_CYCLES-1 differing cycles, so this
    // is the DEBOUNCE_CYCLES-th consecutive one.
    assign accept = differ && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
            level <= IDLE_LEVEL;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= accept && (sync2 != IDLE_LEVEL);
            if (accept) begin
                level <= sync2;
            end
            if (!differ || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/coin_input.sv
// ----------------------------------------------------------------------------
// coin_input
// Coin button front end: debounces the 1, 5 and 10 yuan buttons and turns
// each accepted press into exactly one single-cycle coin strobe.
//
// Ports
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   key1_in   in   raw 1-yuan button
//   key5_in   in   raw 5-yuan button
//   key10_in  in   raw 10-yuan button
//   rmb1      out  registered 1-yuan strobe
//   rmb5      out  registered 5-yuan strobe
//   rmb10     out  registered 10-yuan strobe
//   busy      out  registered; high while any accepted press awaits its strobe
//
// Strobe interface: rmb1/rmb5/rmb10 are fire-and-forget pulses with no
// back-pressure; the accumulator must count every high cycle. At most one
// strobe is high in any cycle. Presses that collide are held in per-channel
// pending bits and issued on later cycles in priority order 1 > 5 > 10.
// A press on a channel whose pending bit is already set is absorbed.
// ----------------------------------------------------------------------------
module coin_input
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key1_in,
    input  logic key5_in,
    input  logic key10_in,
    output logic rmb1,
    output logic rmb5,
    output logic rmb10,
    output logic busy
);

    logic [NUM_COINS-1:0] keys;
    logic [NUM_COINS-1:0] press;
    logic [NUM_COINS-1:0] pending;
    logic [NUM_COINS-1:0] cand;
    logic [NUM_COINS-1:0] grant;
    logic [NUM_COINS-1:0] remain;
    logic [NUM_COINS-1:0] strobe;
    logic                 busy_q;

    always_comb begin
        keys         = '0;
        keys[COIN1]  = key1_in;
        keys[COIN5]  = key5_in;
        keys[COIN10] = key10_in;
    end

    for (genvar i = 0; i < NUM_COINS; i++) begin : gen_ch
        coin_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .key     (keys[i]),
            .press   (press[i])
        );
    end

    // Same-cycle presses compete directly with pending bits, so an
    // uncontended press goes straight to its strobe without touching pending.
    // OR-ing a press into an already-set pending bit is the overrun discard.
    always_comb begin
        cand   = pending | press;
        grant  = pick_coin(cand);
        remain = cand & ~grant;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            strobe  <= '0;
            busy_q  <= 1'b0;
        end else begin
            pending <= remain;
            strobe  <= grant;
            busy_q  <= |remain;
        end
    end

    assign rmb1  = strobe[COIN1];
    assign rmb5  = strobe[COIN5];
    assign rmb10 = strobe[COIN10];
    assign busy  = busy_q;

endmodule

// File: tb/tb_coin_input.sv
// ----------------------------------------------------------------------------
// tb_coin_input
// Self-checking bench for coin_input with DEBOUNCE_CYCLES=4, active-low keys.
// Expected strobes {coin, cycle} are queued when stimulus is driven (directed
// tests) or by a reference model (random test) and popped by the monitor.
// ----------------------------------------------------------------------------
module tb_coin_input;

    localparam int D = 4;
    localparam int W = 34;   // {coin[1:0], cycle[31:0]}

    // ---------------- clock / reset ----------------
    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic key1_in  = 1'b1;
    logic key5_in  = 1'b1;
    logic key10_in = 1'b1;
    logic rmb1, rmb5, rmb10, busy;

    always #5 clk = ~clk;

    coin_input #(
        .DEBOUNCE_CYCLES (D),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .key1_in  (key1_in),
        .key5_in  (key5_in),
        .key10_in (key10_in),
        .rmb1     (rmb1),
        .rmb5     (rmb5),
        .rmb10    (rmb10),
        .busy     (busy)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit use_model = 1'b0;
    int dut_cnt [3] = '{0, 0, 0};
    int mdl_cnt [3] = '{0, 0, 0};
    logic [W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ev(input int coin, input int at);
        logic [1:0] c2;
        c2 = coin[1:0];
        return {c2, at};
    endfunction

    // ---------------- reference model ----------------
    // Active-high view of each key: synchroniser, run length of cycles the
    // synchronised level differs from the debounced level, press, pending.
    logic [2:0] m_s1, m_s2, m_db, m_press, m_pend;
    int         m_run [3];

    always @(posedge clk) begin : model
        logic [2:0] raw, cand, np, ndb;
        int         g;
        int         nrun [3];
        raw = {~key10_in, ~key5_in, ~key1_in};
        np  = '0;
        g   = -1;
        cyc <= cyc + 1;
        if (!reset_n) begin
            m_s1    <= '0;
            m_s2    <= '0;
            m_db    <= '0;
            m_press <= '0;
            m_pend  <= '0;
            m_run   <= '{0, 0, 0};
        end else begin
            ndb  = m_db;
            cand = m_pend | m_press;
            for (int i = 0; i < 3; i++) if (cand[i] && g < 0) g = i;
            if (g >= 0) begin
                cand[g] = 1'b0;
                if (use_model) exp_q.push_back(ev(g, cyc + 1));
            end
            for (int i = 0; i < 3; i++) begin
                nrun[i] = 0;
                if (m_s2[i] != m_db[i]) begin
                    nrun[i] = m_run[i] + 1;
                    if (nrun[i] == D) begin
                        nrun[i] = 0;
                        ndb[i]  = m_s2[i];
                        np[i]   = m_s2[i];
                        if (use_model && m_s2[i]) mdl_cnt[i] <= mdl_cnt[i] + 1;
                    end
                end
            end
            m_pend  <= cand;
            m_press <= np;
            m_db    <= ndb;
            m_run   <= nrun;
            m_s2    <= m_s1;
            m_s1    <= raw;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [2:0]   s;
        logic [W-1:0] got, e;
        int           c;
        s = {rmb10, rmb5, rmb1};
        if (!reset_n) begin
            check("reset_outputs", {s, busy}, 4'b0000);
        end else if (s != 3'b000) begin
            check("onehot", $countones(s), 1);
            c   = s[0] ? 0 : (s[1] ? 1 : 2);
            got = ev(c, cyc);
            if (use_model) dut_cnt[c] <= dut_cnt[c] + 1;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", got, '0);
            end else begin
                e = exp_q.pop_front();
                check("strobe", got, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic k1, input logic k5, input logic k10);
        key1_in  = k1;
        key5_in  = k5;
        key10_in = k10;
    endtask

    task automatic drain(input string tag);
        step(25);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic busy_window(input string tag, input int n, input int lo, input int hi);
        repeat (n) begin
            @(negedge clk);
            check(tag, busy, (cyc >= lo) && (cyc <= hi));
        end
        step(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int c;
        int hold [3];
        logic [2:0] lvl;

        // Reset: outputs low immediately, before any clock edge.
        #1;
        check("reset_immediate", {rmb10, rmb5, rmb1, busy}, 4'b0000);
        step(3);
        reset_n = 1'b1;
        step(10);
        drain("idle_drain");

        // Single 5-yuan press, held 20 cycles, then released.
        key5_in = 1'b0;
        exp_q.push_back(ev(1, cyc + 7));
        step(20);
        key5_in = 1'b1;
        drain("single5_drain");

        // Bouncing 1-yuan key, low runs of 2 cycles are rejected.
        for (int i = 0; i < 3; i++) begin
            key1_in = 1'b0;
            step(2);
            key1_in = 1'b1;
            step(2);
        end
        key1_in = 1'b0;
        exp_q.push_back(ev(0, cyc + 7));
        step(20);
        key1_in = 1'b1;
        drain("bounce1_drain");

        // All three at once: 1, 5, 10 on consecutive cycles.
        set_keys(1'b0, 1'b0, 1'b0);
        c = cyc;
        exp_q.push_back(ev(0, c + 7));
        exp_q.push_back(ev(1, c + 8));
        exp_q.push_back(ev(2, c + 9));
        busy_window("all3_busy", 12, c + 7, c + 8);
        step(10);
        set_keys(1'b1, 1'b1, 1'b1);
        drain("all3_drain");

        // 10-yuan low for D-1 cycles: rejected, busy never rises.
        key10_in = 1'b0;
        step(3);
        key10_in = 1'b1;
        busy_window("short10_busy", 15, -1, -1);
        drain("short10_drain");

        // 10-yuan low for exactly D cycles: accepted.
        key10_in = 1'b0;
        exp_q.push_back(ev(2, cyc + 7));
        step(4);
        key10_in = 1'b1;
        drain("exact10_drain");

        // Reset during a 5-yuan debounce, key still held.
        key5_in = 1'b0;
        step(5);
        reset_n = 1'b0;
        step(4);
        reset_n = 1'b1;
        exp_q.push_back(ev(1, cyc + 7));
        step(20);
        key5_in = 1'b1;
        drain("rst5_drain");

        // Reset while rmb1 is high and 5/10 are pending: cleared at once,
        // then the held keys are pressed again after release.
        set_keys(1'b0, 1'b0, 1'b0);
        c = cyc;
        exp_q.push_back(ev(0, c + 7));
        repeat (7) @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_pending_async", {rmb10, rmb5, rmb1, busy}, 4'b0000);
        step(3);
        reset_n = 1'b1;
        c = cyc;
        exp_q.push_back(ev(0, c + 7));
        exp_q.push_back(ev(1, c + 8));
        exp_q.push_back(ev(2, c + 9));
        step(20);
        set_keys(1'b1, 1'b1, 1'b1);
        drain("rst_pending_drain");

        // Random bounce on all keys against the reference model.
        use_model = 1'b1;
        hold = '{0, 0, 0};
        lvl  = 3'b000;
        for (int t = 0; t < 10000; t++) begin
            for (int k = 0; k < 3; k++) begin
                if (hold[k] == 0) begin
                    lvl[k]  = 1'($urandom_range(0, 1));
                    hold[k] = $urandom_range(1, 8);
                end
                hold[k]--;
            end
            set_keys(~lvl[0], ~lvl[1], ~lvl[2]);
            step(1);
        end
        set_keys(1'b1, 1'b1, 1'b1);
        step(30);
        use_model = 1'b0;
        step(1);
        check("rand_cnt1", dut_cnt[0], mdl_cnt[0]);
        check("rand_cnt5", dut_cnt[1], mdl_cnt[1]);
        check("rand_cnt10", dut_cnt[2], mdl_cnt[2]);
        check("rand_any_press", (mdl_cnt[0] > 0) && (mdl_cnt[1] > 0) && (mdl_cnt[2] > 0), 1);
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
